// File: rtl/cr_xp10_decomp_fhp_pt_fwd_if.sv
// Purpose: bundles the PT FIFO pop side and the 64b AXI4-stream output of the PT forwarder.
// Signals:
//   pt_empty/pt_rd/pt_data/pt_sot/pt_eot : PT FIFO read port (data valid the cycle after pt_rd)
//   m_tvalid/m_tready/m_tdata/m_tlast/m_tuser : AXI4-stream master toward the output mux
// Modports: master = forwarder view, slave = FIFO + stream sink view.
interface cr_xp10_decomp_fhp_pt_fwd_if;
   logic        pt_empty;
   logic        pt_rd;
   logic [63:0] pt_data;
   logic        pt_sot;
   logic        pt_eot;
   logic        m_tvalid;
   logic        m_tready;
   logic [63:0] m_tdata;
   logic        m_tlast;
   logic [7:0]  m_tuser;

   modport master (
      input  pt_empty, pt_data, pt_sot, pt_eot, m_tready,
      output pt_rd, m_tvalid, m_tdata, m_tlast, m_tuser
   );

   modport slave (
      output pt_empty, pt_data, pt_sot, pt_eot, m_tready,
      input  pt_rd, m_tvalid, m_tdata, m_tlast, m_tuser
   );
endinterface

// File: rtl/cr_xp10_decomp_fhp_pt_fwd.sv
// Purpose: pops PT TLV words, checks sot/eot/length framing, forwards good words on AXI4-stream.
//   Malformed TLVs are cut with tlast, the remainder flushed to eot, and a sticky error raised.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   bus (master)   : PT FIFO read port and AXI4-stream output
//   tlv_cnt        : saturating count of TLVs closed with tlast (good or truncated)
//   fwd_error      : sticky framing error
//   fwd_error_pls  : one-cycle pulse per framing error event
module cr_xp10_decomp_fhp_pt_fwd #(
   parameter int unsigned N_SKID    = 2,
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   cr_xp10_decomp_fhp_pt_fwd_if.master bus,
   output logic [CNT_WIDTH-1:0]       tlv_cnt,
   output logic                       fwd_error,
   output logic                       fwd_error_pls
);

   localparam int unsigned PTR_W = (N_SKID > 2) ? 2 : 1;
   localparam int unsigned OCC_W = 3;

   typedef enum logic [1:0] {SOT_WAIT, BODY, FLUSH} state_t;

   typedef struct packed {
      logic [63:0] data;
      logic        last;
      logic [7:0]  user;
   } beat_t;

   beat_t                r_skid [N_SKID];
   logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
   logic [OCC_W-1:0]     r_occ;
   logic                 r_rd_q;
   state_t               r_state, w_state_n;
   logic [7:0]           r_type, w_type_n;
   logic [7:0]           r_len, w_len_n;
   logic [7:0]           r_wcnt, w_wcnt_n;
   logic [CNT_WIDTH-1:0] r_tlv_cnt;
   logic                 r_err, r_err_pls;

   logic                 w_pop, w_rd, w_push, w_err, w_done;
   beat_t                w_beat;
   logic [7:0]           w_hdr_len, w_cnt_inc;

   // A word leaving the skid this cycle frees its slot for a read issued now, giving 1 word/clk.
   assign w_pop = (r_occ != '0) && bus.m_tready;
   assign w_rd  = rst_n && !bus.pt_empty &&
                  ((r_occ - OCC_W'(w_pop) + OCC_W'(r_rd_q)) < OCC_W'(N_SKID));

   assign bus.pt_rd    = w_rd;
   assign bus.m_tvalid = (r_occ != '0);
   assign bus.m_tdata  = r_skid[r_rd_ptr].data;
   assign bus.m_tlast  = r_skid[r_rd_ptr].last;
   assign bus.m_tuser  = r_skid[r_rd_ptr].user;

   assign tlv_cnt       = r_tlv_cnt;
   assign fwd_error     = r_err;
   assign fwd_error_pls = r_err_pls;

   assign w_hdr_len = bus.pt_data[15:8];
   assign w_cnt_inc = r_wcnt + 8'd1;

   // Framing FSM: evaluates the word captured this cycle (r_rd_q marks a returning read).
   always_comb begin
      w_state_n   = r_state;
      w_type_n    = r_type;
      w_len_n     = r_len;
      w_wcnt_n    = r_wcnt;
      w_push      = 1'b0;
      w_err       = 1'b0;
      w_done      = 1'b0;
      w_beat.data = bus.pt_data;
      w_beat.last = 1'b0;
      w_beat.user = r_type;
      if (r_rd_q) begin
         unique case (r_state)
            SOT_WAIT: begin
               if (bus.pt_sot) begin
                  w_type_n    = bus.pt_data[7:0];
                  w_len_n     = w_hdr_len;
                  w_wcnt_n    = 8'd1;
                  w_push      = 1'b1;
                  w_beat.user = bus.pt_data[7:0];
                  if ((w_hdr_len <= 8'd1) || bus.pt_eot) begin
                     // Single-word TLV or malformed header: close it on this word.
                     w_beat.last = 1'b1;
                     w_done      = 1'b1;
                     w_err       = !((w_hdr_len == 8'd1) && bus.pt_eot);
                     w_state_n   = bus.pt_eot ? SOT_WAIT : FLUSH;
                  end else begin
                     w_state_n = BODY;
                  end
               end else begin
                  // Orphan word: dropped, rest of its TLV discarded.
                  w_err     = 1'b1;
                  w_state_n = bus.pt_eot ? SOT_WAIT : FLUSH;
               end
            end
            BODY: begin
               w_wcnt_n = w_cnt_inc;
               w_push   = 1'b1;
               if (bus.pt_sot) begin
                  w_err       = 1'b1;
                  w_beat.last = 1'b1;
                  w_done      = 1'b1;
                  w_state_n   = bus.pt_eot ? SOT_WAIT : FLUSH;
               end else if (bus.pt_eot) begin
                  w_err       = (w_cnt_inc != r_len);
                  w_beat.last = 1'b1;
                  w_done      = 1'b1;
                  w_state_n   = SOT_WAIT;
               end else if (w_cnt_inc == r_len) begin
                  w_err       = 1'b1;
                  w_beat.last = 1'b1;
                  w_done      = 1'b1;
                  w_state_n   = FLUSH;
               end
            end
            FLUSH: begin
               if (bus.pt_eot) w_state_n = SOT_WAIT;
            end
            default: w_state_n = SOT_WAIT;
         endcase
      end
   end

   // Skid buffer, read tracking, FSM state and status registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(N_SKID); i++) r_skid[i] <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_occ     <= '0;
         r_rd_q    <= 1'b0;
         r_state   <= SOT_WAIT;
         r_type    <= '0;
         r_len     <= '0;
         r_wcnt    <= '0;
         r_tlv_cnt <= '0;
         r_err     <= 1'b0;
         r_err_pls <= 1'b0;
      end else begin
         r_rd_q  <= w_rd;
         r_state <= w_state_n;
         r_type  <= w_type_n;
         r_len   <= w_len_n;
         r_wcnt  <= w_wcnt_n;
         if (w_push) begin
            r_skid[r_wr_ptr] <= w_beat;
            r_wr_ptr <= (r_wr_ptr == PTR_W'(N_SKID - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == PTR_W'(N_SKID - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
         end
         r_occ <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
         if (w_done && (r_tlv_cnt != '1)) r_tlv_cnt <= r_tlv_cnt + CNT_WIDTH'(1);
         r_err     <= r_err | w_err;
         r_err_pls <= w_err;
      end
   end

endmodule

// File: tb/tb_cr_xp10_decomp_fhp_pt_fwd.sv
// Scoreboard bench for the PT forwarder: a FIFO model feeds directed TLVs, expected beats are
// queued as stimulus is issued, and a monitor pops/compares on every AXI4-stream transfer.
module tb_cr_xp10_decomp_fhp_pt_fwd;
   localparam int unsigned N_SKID = 2;
   localparam int unsigned CW     = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CW-1:0] tlv_cnt;
   logic          fwd_error, fwd_error_pls;

   always #5 clk = ~clk;

   cr_xp10_decomp_fhp_pt_fwd_if bus ();

   cr_xp10_decomp_fhp_pt_fwd #(.N_SKID(N_SKID), .CNT_WIDTH(CW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus),
      .tlv_cnt       (tlv_cnt),
      .fwd_error     (fwd_error),
      .fwd_error_pls (fwd_error_pls)
   );

   typedef struct packed { logic [63:0] d; logic sot; logic eot; } fw_t;
   typedef struct packed { logic [63:0] d; logic last; logic [7:0] u; } ex_t;

   fw_t fifo_q[$];
   ex_t sb_q[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int pls_cnt = 0;
   int ready_mode = 0;      // 0: ready high, 1: toggle, 2: ready low
   bit rand_empty = 1'b0;
   bit lat_arm = 1'b0;
   int first_rd = -1;
   int first_v = -1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] hdr(input logic [7:0] t, input logic [7:0] len);
      return {32'hC0DE_F00D, 16'h0000, len, t};
   endfunction

   function automatic logic [63:0] body(input logic [7:0] tag, input logic [7:0] idx);
      return {32'hB0D1_0000, tag, 16'h0000, idx};
   endfunction

   task automatic push(input logic [63:0] d, input logic sot, input logic eot,
                       input bit exp, input logic last, input logic [7:0] user);
      fw_t w;
      ex_t e;
      w.d = d; w.sot = sot; w.eot = eot;
      fifo_q.push_back(w);
      if (exp) begin
         e.d = d; e.last = last; e.u = user;
         sb_q.push_back(e);
      end
   endtask

   // PT FIFO model: pop on pt_rd, data appears the following cycle.
   always @(posedge clk) begin
      fw_t w;
      cyc <= cyc + 1;
      if (bus.pt_rd && (fifo_q.size() > 0)) begin
         w = fifo_q.pop_front();
         bus.pt_data <= w.d;
         bus.pt_sot  <= w.sot;
         bus.pt_eot  <= w.eot;
      end
      bus.pt_empty <= (fifo_q.size() == 0) || (rand_empty && ($urandom_range(0, 1) == 1));
   end

   // Sink ready pattern, changed just after the active edge.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       bus.m_tready = 1'b1;
         1:       bus.m_tready = (bus.m_tready === 1'b1) ? 1'b0 : 1'b1;
         default: bus.m_tready = 1'b0;
      endcase
   end

   // Monitor: protocol checks and scoreboard compare, sampled on the falling edge.
   bit          p_stall = 1'b0;
   logic [63:0] p_data;
   logic        p_last;
   logic [7:0]  p_user;
   always @(negedge clk) begin
      ex_t e;
      if (rst_n) begin
         if (bus.pt_rd && bus.pt_empty) chk("pt_rd_while_empty", 1, 0);
         if (dut.r_occ > 3'(N_SKID)) chk("skid_overflow", 64'(dut.r_occ), 64'(N_SKID));
         if (p_stall) begin
            chk("stall_valid", 64'(bus.m_tvalid), 1);
            chk("stall_data", bus.m_tdata, p_data);
            chk("stall_last", 64'(bus.m_tlast), 64'(p_last));
            chk("stall_user", 64'(bus.m_tuser), 64'(p_user));
         end
         if (lat_arm && bus.pt_rd && (first_rd < 0)) first_rd = cyc;
         if (lat_arm && bus.m_tvalid && (first_v < 0)) first_v = cyc;
         if (bus.m_tvalid && bus.m_tready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_beat", bus.m_tdata, 0);
            end else begin
               e = sb_q.pop_front();
               chk("beat_data", bus.m_tdata, e.d);
               chk("beat_last", 64'(bus.m_tlast), 64'(e.last));
               chk("beat_user", 64'(bus.m_tuser), 64'(e.u));
            end
         end
         if (fwd_error_pls) pls_cnt++;
         p_stall = bus.m_tvalid && !bus.m_tready;
         p_data  = bus.m_tdata;
         p_last  = bus.m_tlast;
         p_user  = bus.m_tuser;
      end else begin
         p_stall = 1'b0;
      end
   end

   // Wait until FIFO, scoreboard and pipeline have been quiet for several cycles.
   task automatic wait_idle(input string name);
      int quiet = 0;
      bit done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         if ((fifo_q.size() == 0) && (sb_q.size() == 0) && !bus.m_tvalid && !bus.pt_rd) quiet++;
         else quiet = 0;
         if (quiet >= 4) done = 1'b1;
      end
      if (!done) chk({name, "_drain_timeout"}, 64'(sb_q.size()), 0);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: got running expected finished");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: good TLV len 4, ready high, latency measured
      lat_arm = 1'b1;
      push(hdr(8'h11, 8'd4), 1, 0, 1, 0, 8'h11);
      push(body(8'h11, 1), 0, 0, 1, 0, 8'h11);
      push(body(8'h11, 2), 0, 0, 1, 0, 8'h11);
      push(body(8'h11, 3), 0, 1, 1, 1, 8'h11);
      wait_idle("t1");
      lat_arm = 1'b0;
      chk("t1_latency", 64'(first_v - first_rd), 2);
      chk("t1_tlv_cnt", 64'(tlv_cnt), 1);
      chk("t1_fwd_error", 64'(fwd_error), 0);
      chk("t1_pulses", 64'(pls_cnt), 0);

      // 2: same TLV under toggling ready and random empty
      ready_mode = 1; rand_empty = 1'b1;
      push(hdr(8'h22, 8'd4), 1, 0, 1, 0, 8'h22);
      push(body(8'h22, 1), 0, 0, 1, 0, 8'h22);
      push(body(8'h22, 2), 0, 0, 1, 0, 8'h22);
      push(body(8'h22, 3), 0, 1, 1, 1, 8'h22);
      wait_idle("t2");
      chk("t2_tlv_cnt", 64'(tlv_cnt), 2);
      chk("t2_pulses", 64'(pls_cnt), 0);
      ready_mode = 0; rand_empty = 1'b0;

      // 3: len 5, eot on word 3 -> truncated at 3
      push(hdr(8'h33, 8'd5), 1, 0, 1, 0, 8'h33);
      push(body(8'h33, 1), 0, 0, 1, 0, 8'h33);
      push(body(8'h33, 2), 0, 1, 1, 1, 8'h33);
      wait_idle("t3");
      chk("t3_pulses", 64'(pls_cnt), 1);
      chk("t3_fwd_error", 64'(fwd_error), 1);
      chk("t3_tlv_cnt", 64'(tlv_cnt), 3);

      // 4: len 2, eot on word 4 -> words 3-4 flushed, then good TLV
      push(hdr(8'h44, 8'd2), 1, 0, 1, 0, 8'h44);
      push(body(8'h44, 1), 0, 0, 1, 1, 8'h44);
      push(body(8'h44, 2), 0, 0, 0, 0, 8'h00);
      push(body(8'h44, 3), 0, 1, 0, 0, 8'h00);
      push(hdr(8'h45, 8'd3), 1, 0, 1, 0, 8'h45);
      push(body(8'h45, 1), 0, 0, 1, 0, 8'h45);
      push(body(8'h45, 2), 0, 1, 1, 1, 8'h45);
      wait_idle("t4");
      chk("t4_pulses", 64'(pls_cnt), 2);
      chk("t4_tlv_cnt", 64'(tlv_cnt), 5);

      // 5: orphan word without sot, flushed to eot, then good TLV
      push(body(8'h50, 0), 0, 0, 0, 0, 8'h00);
      push(body(8'h50, 1), 0, 0, 0, 0, 8'h00);
      push(body(8'h50, 2), 0, 1, 0, 0, 8'h00);
      push(hdr(8'h55, 8'd2), 1, 0, 1, 0, 8'h55);
      push(body(8'h55, 1), 0, 1, 1, 1, 8'h55);
      wait_idle("t5");
      chk("t5_pulses", 64'(pls_cnt), 3);
      chk("t5_tlv_cnt", 64'(tlv_cnt), 6);

      // 5b: len 0 header with sot+eot is malformed but still closed with tlast
      push(hdr(8'h66, 8'd0), 1, 1, 1, 1, 8'h66);
      wait_idle("t5b");
      chk("t5b_pulses", 64'(pls_cnt), 4);
      chk("t5b_tlv_cnt", 64'(tlv_cnt), 7);

      // 6: reset mid-TLV with full skid and ready low
      ready_mode = 2;
      push(hdr(8'h77, 8'd4), 1, 0, 0, 0, 8'h00);
      push(body(8'h77, 1), 0, 0, 0, 0, 8'h00);
      push(body(8'h77, 2), 0, 0, 0, 0, 8'h00);
      push(body(8'h77, 3), 0, 1, 0, 0, 8'h00);
      repeat (8) @(negedge clk);
      chk("t6_skid_full", 64'(dut.r_occ), 64'(N_SKID));
      chk("t6_pt_rd_blocked", 64'(bus.pt_rd), 0);
      rst_n = 1'b0;
      fifo_q.delete();
      sb_q.delete();
      @(negedge clk);
      chk("t6_rst_pt_rd", 64'(bus.pt_rd), 0);
      chk("t6_rst_tvalid", 64'(bus.m_tvalid), 0);
      chk("t6_rst_tlast", 64'(bus.m_tlast), 0);
      chk("t6_rst_tdata", bus.m_tdata, 0);
      chk("t6_rst_tuser", 64'(bus.m_tuser), 0);
      chk("t6_rst_tlv_cnt", 64'(tlv_cnt), 0);
      chk("t6_rst_fwd_error", 64'(fwd_error), 0);
      chk("t6_rst_err_pls", 64'(fwd_error_pls), 0);
      pls_cnt = 0;
      ready_mode = 0;
      @(negedge clk);
      rst_n = 1'b1;
      push(hdr(8'h88, 8'd1), 1, 1, 1, 1, 8'h88);
      wait_idle("t6");
      chk("t6_tlv_cnt", 64'(tlv_cnt), 1);
      chk("t6_fwd_error", 64'(fwd_error), 0);
      chk("t6_pulses", 64'(pls_cnt), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
